// File: rtl/cpu_pkg.sv
`default_nettype none
//----------------------------------------------------------------------------
// cpu_pkg - shared widths and constants for the ID-stage operand fetch. Rev 1.0
//----------------------------------------------------------------------------
package cpu_pkg;

  localparam int DW     = 32;
  localparam int AW     = 5;
  localparam int CTRL_W = 8;

  localparam logic [AW-1:0] REG_ZERO = '0;

endpackage
`default_nettype wire

// File: rtl/op_scoreboard.sv
`default_nettype none
//----------------------------------------------------------------------------
// op_scoreboard - per-register pending-write bits with a 2-port hazard query. Rev 1.0
//----------------------------------------------------------------------------
module op_scoreboard
  import cpu_pkg::*;
#(
  parameter int AW = cpu_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_en_i,
  input  logic [AW-1:0] set_addr_i,
  input  logic          clr_en_i,
  input  logic [AW-1:0] clr_addr_i,
  input  logic [AW-1:0] q1_addr_i,
  input  logic [AW-1:0] q2_addr_i,
  output logic          q1_pend_o,
  output logic          q2_pend_o
);

  localparam int NREG = 1 << AW;

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  // Clear is applied first so that a same-cycle set of the same bit wins.
  always_comb begin
    pend_d = pend_q;
    if (clr_en_i) pend_d[clr_addr_i] = 1'b0;
    if (set_en_i) pend_d[set_addr_i] = 1'b1;
    pend_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign q1_pend_o = pend_q[q1_addr_i];
  assign q2_pend_o = pend_q[q2_addr_i];

endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
//----------------------------------------------------------------------------
// operand_fetch - ID-stage operand fetch, hazard stall and ID/EX register.
// Macro OPERAND_FWD_EN enables EX/MEM and WB bypassing.               Rev 1.0
//----------------------------------------------------------------------------
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int DW = cpu_pkg::DW,
  parameter int AW = cpu_pkg::AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     in_rs,
  input  logic [AW-1:0]     in_rt,
  input  logic              in_use_rs,
  input  logic              in_use_rt,
  input  logic [AW-1:0]     in_rd,
  input  logic              in_wr,
  input  logic              in_is_load,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [AW-1:0]     rf_addr1,
  output logic [AW-1:0]     rf_addr2,
  input  logic [DW-1:0]     rf_data1,
  input  logic [DW-1:0]     rf_data2,
  input  logic              ex_fwd_valid,
  input  logic [AW-1:0]     ex_fwd_addr,
  input  logic [DW-1:0]     ex_fwd_data,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DW-1:0]     wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_op1,
  output logic [DW-1:0]     out_op2,
  output logic [AW-1:0]     out_rd,
  output logic              out_wr,
  output logic              out_is_load,
  output logic [CTRL_W-1:0] out_ctrl
);

  logic              valid_q, valid_d;
  logic [DW-1:0]     op1_q, op1_d;
  logic [DW-1:0]     op2_q, op2_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              load_q, load_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  logic [DW-1:0] w_op1, w_op2;
  logic          w_pend1, w_pend2;
  logic          w_pend_hit1, w_pend_hit2;
  logic          w_out_hit1, w_out_hit2;
  logic          w_haz1, w_haz2;
  logic          w_sb_set;
  logic          w_take;

  assign rf_addr1 = in_rs;
  assign rf_addr2 = in_rt;

`ifdef OPERAND_FWD_EN
  // Later assignments take priority: r0, then EX/MEM, then WB, then RF.
  always_comb begin
    w_op1 = rf_data1;
    if (wb_valid && wb_addr == in_rs)         w_op1 = wb_data;
    if (ex_fwd_valid && ex_fwd_addr == in_rs) w_op1 = ex_fwd_data;
    if (in_rs == REG_ZERO)                    w_op1 = '0;
    w_op2 = rf_data2;
    if (wb_valid && wb_addr == in_rt)         w_op2 = wb_data;
    if (ex_fwd_valid && ex_fwd_addr == in_rt) w_op2 = ex_fwd_data;
    if (in_rt == REG_ZERO)                    w_op2 = '0;
  end

  assign w_pend_hit1 = w_pend1 && !(wb_valid && wb_addr == in_rs);
  assign w_pend_hit2 = w_pend2 && !(wb_valid && wb_addr == in_rt);
  assign w_sb_set    = valid_q && out_ready && !flush && wr_q &&
                       (rd_q != REG_ZERO) && load_q;
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_fwd_valid, ex_fwd_addr, ex_fwd_data, wb_data};

  assign w_op1 = (in_rs == REG_ZERO) ? '0 : rf_data1;
  assign w_op2 = (in_rt == REG_ZERO) ? '0 : rf_data2;

  // Without bypass a consumer waits for the register file write to land.
  assign w_pend_hit1 = w_pend1;
  assign w_pend_hit2 = w_pend2;
  assign w_sb_set    = valid_q && out_ready && !flush && wr_q &&
                       (rd_q != REG_ZERO);
`endif

  assign w_out_hit1 = valid_q && wr_q && (rd_q == in_rs);
  assign w_out_hit2 = valid_q && wr_q && (rd_q == in_rt);
  assign w_haz1     = in_use_rs && (in_rs != REG_ZERO) && (w_out_hit1 || w_pend_hit1);
  assign w_haz2     = in_use_rt && (in_rt != REG_ZERO) && (w_out_hit2 || w_pend_hit2);

  assign in_ready = !w_haz1 && !w_haz2 && (!valid_q || out_ready) && !flush;
  assign w_take   = in_valid && in_ready;

  op_scoreboard #(
    .AW(AW)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .set_en_i  (w_sb_set),
    .set_addr_i(rd_q),
    .clr_en_i  (wb_valid),
    .clr_addr_i(wb_addr),
    .q1_addr_i (in_rs),
    .q2_addr_i (in_rt),
    .q1_pend_o (w_pend1),
    .q2_pend_o (w_pend2)
  );

  always_comb begin
    valid_d = valid_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    load_d  = load_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (w_take) begin
      valid_d = 1'b1;
      op1_d   = w_op1;
      op2_d   = w_op2;
      rd_d    = in_rd;
      wr_d    = in_wr;
      load_d  = in_is_load;
      ctrl_d  = in_ctrl;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      rd_q    <= '0;
      wr_q    <= 1'b0;
      load_q  <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      load_q  <= load_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_op1     = op1_q;
  assign out_op2     = op2_q;
  assign out_rd      = rd_q;
  assign out_wr      = wr_q;
  assign out_is_load = load_q;
  assign out_ctrl    = ctrl_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
//----------------------------------------------------------------------------
// tb_operand_fetch - randomized scoreboard bench for operand_fetch. Rev 1.0
//----------------------------------------------------------------------------
module tb_operand_fetch;
  import cpu_pkg::*;

  localparam int NCYC = 4000;
  localparam int NREG = 1 << AW;

  typedef struct {
    logic [DW-1:0]     op1;
    logic [DW-1:0]     op2;
    logic [AW-1:0]     rd;
    logic              wr;
    logic              is_load;
    logic [CTRL_W-1:0] ctrl;
  } item_t;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [AW-1:0]     in_rs, in_rt, in_rd;
  logic              in_use_rs, in_use_rt, in_wr, in_is_load;
  logic [CTRL_W-1:0] in_ctrl;
  logic [AW-1:0]     rf_addr1, rf_addr2;
  logic [DW-1:0]     rf_data1, rf_data2;
  logic              ex_fwd_valid;
  logic [AW-1:0]     ex_fwd_addr;
  logic [DW-1:0]     ex_fwd_data;
  logic              wb_valid;
  logic [AW-1:0]     wb_addr;
  logic [DW-1:0]     wb_data;
  logic              flush;
  logic              out_valid, out_ready;
  logic [DW-1:0]     out_op1, out_op2;
  logic [AW-1:0]     out_rd;
  logic              out_wr, out_is_load;
  logic [CTRL_W-1:0] out_ctrl;

  operand_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_use_rs   (in_use_rs),
    .in_use_rt   (in_use_rt),
    .in_rd       (in_rd),
    .in_wr       (in_wr),
    .in_is_load  (in_is_load),
    .in_ctrl     (in_ctrl),
    .rf_addr1    (rf_addr1),
    .rf_addr2    (rf_addr2),
    .rf_data1    (rf_data1),
    .rf_data2    (rf_data2),
    .ex_fwd_valid(ex_fwd_valid),
    .ex_fwd_addr (ex_fwd_addr),
    .ex_fwd_data (ex_fwd_data),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op1     (out_op1),
    .out_op2     (out_op2),
    .out_rd      (out_rd),
    .out_wr      (out_wr),
    .out_is_load (out_is_load),
    .out_ctrl    (out_ctrl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  item_t         exp_q[$];
  bit            pend_m [NREG];
  logic [DW-1:0] regs   [NREG];
  int            checks;
  int            errors;
  bit            armed;
  bit            check_reset_fields;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_operand(input logic [AW-1:0] s, input logic [DW-1:0] rf);
    if (s == 0) return '0;
`ifdef OPERAND_FWD_EN
    if (ex_fwd_valid && ex_fwd_addr == s) return ex_fwd_data;
    if (wb_valid && wb_addr == s) return wb_data;
`endif
    return rf;
  endfunction

  function automatic bit model_hazard(input logic use_s, input logic [AW-1:0] s);
    if (!use_s || s == 0) return 1'b0;
    if (exp_q.size() != 0 && exp_q[0].wr && exp_q[0].rd == s) return 1'b1;
`ifdef OPERAND_FWD_EN
    return pend_m[s] && !(wb_valid && wb_addr == s);
`else
    return pend_m[s];
`endif
  endfunction

  // Stimulus and reference model.
  initial begin
    checks = 0;
    errors = 0;
    armed = 1'b0;
    check_reset_fields = 1'b0;
    reset = 1'b0;
    in_valid = 1'b0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_use_rs = 1'b0; in_use_rt = 1'b0; in_wr = 1'b0; in_is_load = 1'b0; in_ctrl = '0;
    rf_data1 = '0; rf_data2 = '0;
    ex_fwd_valid = 1'b0; ex_fwd_addr = '0; ex_fwd_data = '0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    flush = 1'b0; out_ready = 1'b0;
    foreach (regs[i]) regs[i] = DW'($urandom);
    foreach (pend_m[i]) pend_m[i] = 1'b0;
    repeat (2) @(posedge clk);
    armed = 1'b1;
    check_reset_fields = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      item_t         it;
      logic          exp_ready;
      logic          take;
      logic          sb_set;
      logic [AW-1:0] set_rd;
      @(negedge clk);
      reset        = ($urandom_range(0, 99) != 0);
      in_valid     = ($urandom_range(0, 3) != 0);
      in_rs        = AW'($urandom_range(0, 7));
      in_rt        = AW'($urandom_range(0, 7));
      in_use_rs    = ($urandom_range(0, 4) != 0);
      in_use_rt    = ($urandom_range(0, 4) != 0);
      in_rd        = AW'($urandom_range(0, 7));
      in_wr        = ($urandom_range(0, 3) != 0);
      in_is_load   = ($urandom_range(0, 2) == 0);
      in_ctrl      = CTRL_W'($urandom);
      rf_data1     = regs[in_rs];
      rf_data2     = regs[in_rt];
      ex_fwd_valid = ($urandom_range(0, 2) == 0);
      ex_fwd_addr  = AW'($urandom_range(0, 7));
      ex_fwd_data  = DW'($urandom);
      wb_valid     = ($urandom_range(0, 2) == 0);
      wb_addr      = AW'($urandom_range(0, 7));
      wb_data      = DW'($urandom);
      out_ready    = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 15) == 0);
      #1;

      if (check_reset_fields) begin
        check("reset_valid", 64'(out_valid), 64'(0));
        check("reset_op1", 64'(out_op1), 64'(0));
        check("reset_op2", 64'(out_op2), 64'(0));
        check("reset_meta", 64'({out_rd, out_wr, out_is_load, out_ctrl}), 64'(0));
        check_reset_fields = 1'b0;
      end

      exp_ready = !model_hazard(in_use_rs, in_rs) && !model_hazard(in_use_rt, in_rt) &&
                  (exp_q.size() == 0 || out_ready) && !flush;
      check("in_ready", 64'(in_ready), 64'(exp_ready));
      check("rf_addr", 64'({rf_addr1, rf_addr2}), 64'({in_rs, in_rt}));
      take       = in_valid && exp_ready;
      it.op1     = model_operand(in_rs, rf_data1);
      it.op2     = model_operand(in_rt, rf_data2);
      it.rd      = in_rd;
      it.wr      = in_wr;
      it.is_load = in_is_load;
      it.ctrl    = in_ctrl;
      sb_set     = 1'b0;
      set_rd     = '0;
      if (exp_q.size() != 0) begin
        set_rd = exp_q[0].rd;
`ifdef OPERAND_FWD_EN
        sb_set = out_ready && !flush && exp_q[0].wr && exp_q[0].rd != 0 && exp_q[0].is_load;
`else
        sb_set = out_ready && !flush && exp_q[0].wr && exp_q[0].rd != 0;
`endif
      end

      @(posedge clk);
      if (!reset) begin
        exp_q.delete();
        foreach (pend_m[i]) pend_m[i] = 1'b0;
        check_reset_fields = 1'b1;
      end else begin
        if (wb_valid && wb_addr != 0) pend_m[wb_addr] = 1'b0;
        if (sb_set) pend_m[set_rd] = 1'b1;
        if (take) exp_q.push_back(it);
      end
      if (wb_valid && wb_addr != 0) regs[wb_addr] = wb_data;
    end

    @(negedge clk);
    #5;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Monitor: compares the ID/EX register against the head of the expected queue.
  initial begin
    wait (armed);
    forever begin
      @(negedge clk);
      #3;
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("out_op1", 64'(out_op1), 64'(exp_q[0].op1));
        check("out_op2", 64'(out_op2), 64'(exp_q[0].op2));
        check("out_meta", 64'({out_rd, out_wr, out_is_load, out_ctrl}),
              64'({exp_q[0].rd, exp_q[0].wr, exp_q[0].is_load, exp_q[0].ctrl}));
        if (flush || out_ready) void'(exp_q.pop_front());
      end
    end
  end

endmodule
`default_nettype wire
